acc42_stage: RTL

ACC42_STAGE -- requirements
Module: acc42_stage

---
 rtl/acc42_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/acc42_stage.sv
// Multi-term accumulator stage driving an external combinational adder.
// A start request loads a term count; each accepted term registers the adder sum.
module acc42_stage #(
   parameter int unsigned WIDTH = 42,
   parameter int unsigned CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_num_terms,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_add_term1,
   output logic [WIDTH-1:0] o_add_term2,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_cout,
   output logic             o_valid,
   input  logic             i_result_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_overflow,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               ovf_q, ovf_d;
   logic               ready_q, valid_q, busy_q;
   logic               accept;
   logic               last_term;

   always_comb begin
      accept    = i_valid & ready_q;
      acc_d     = i_sum;
      ovf_d     = ovf_q | i_cout;
      rem_d     = (rem_q != '0) ? rem_q - CNT_W'(1) : '0;
      last_term = (rem_q == CNT_W'(1));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  acc_q  <= '0;
                  ovf_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (i_num_terms != '0) begin
                     rem_q   <= i_num_terms;
                     ready_q <= 1'b1;
                     state_q <= S_ACCUM;
                  end else begin
                     // Zero-term request completes immediately with a zero result.
                     rem_q   <= '0;
                     valid_q <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  ovf_q <= ovf_d;
                  rem_q <= rem_d;
                  if (last_term) begin
                     ready_q <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (i_result_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               ready_q <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ready_q is high exactly in ACCUM, so the adder input is quiet elsewhere.
   assign o_add_term1 = acc_q;
   assign o_add_term2 = ready_q ? i_data : '0;
   assign o_ready     = ready_q;
   assign o_valid     = valid_q;
   assign o_busy      = busy_q;
   assign o_result    = acc_q;
   assign o_overflow  = ovf_q;

endmodule
